// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Program counter owner and next-PC sequencer for fetch; buffers
//               redirects that arrive under stall. Optional build macro
//               ALIGN_CHECK_EN traps misaligned targets to TRAP_PC.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_PC  = 32'h0000_0080
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [1:0]  jump,
    input  logic [31:0] jump_target,
    input  logic [31:0] branch_target,
    input  logic [31:0] jr_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        flush,
    output logic        pending,
    output logic        illegal_sel,
    output logic        misalign
);

    localparam logic [1:0] c_sel_illegal = 2'b11;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_pend_pc;
    logic        r_flush;
    logic        r_misalign;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_pend_pc_nxt;
    logic        w_flush_nxt;
    logic        w_misalign_nxt;
    logic        w_legal;
    logic        w_apply;
    logic [31:0] w_sel_target;
    logic [31:0] w_apply_tgt;
    logic [31:0] w_applied_pc;
    logic        w_tgt_misalign;

    assign pc_plus4    = r_pc + 32'd4;
    assign illegal_sel = redirect_valid && (jump == c_sel_illegal);
    assign w_legal     = redirect_valid && (jump != c_sel_illegal);

    always_comb begin
        case (jump)
            2'b00:   w_sel_target = jump_target;
            2'b01:   w_sel_target = branch_target;
            2'b10:   w_sel_target = jr_target;
            default: w_sel_target = jump_target;
        endcase
    end

    // A live request always beats the buffered one when a redirect is applied.
    assign w_apply_tgt = w_legal ? w_sel_target : r_pend_pc;

`ifdef ALIGN_CHECK_EN
    assign w_tgt_misalign = (w_apply_tgt[1:0] != 2'b00);
    assign w_applied_pc   = w_tgt_misalign ? TRAP_PC : w_apply_tgt;
`else
    logic w_unused;
    assign w_tgt_misalign = 1'b0;
    assign w_applied_pc   = {w_apply_tgt[31:2], 2'b00};
    assign w_unused       = ^{TRAP_PC, w_apply_tgt[1:0]};
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_pend_pc_nxt  = r_pend_pc;
        w_flush_nxt    = 1'b0;
        w_misalign_nxt = 1'b0;
        w_apply        = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (!stall) begin
                    if (w_legal) begin
                        w_apply = 1'b1;
                    end else begin
                        w_pc_nxt = pc_plus4;
                    end
                end else if (w_legal) begin
                    w_pend_pc_nxt = w_sel_target;
                    w_state_nxt   = ST_PEND;
                end
            end
            ST_PEND: begin
                if (stall) begin
                    if (w_legal) begin
                        w_pend_pc_nxt = w_sel_target;
                    end
                end else begin
                    w_apply     = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
        if (w_apply) begin
            w_pc_nxt       = w_applied_pc;
            w_flush_nxt    = 1'b1;
            w_misalign_nxt = w_tgt_misalign;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_RUN;
            r_pc       <= RESET_PC;
            r_pend_pc  <= 32'h0000_0000;
            r_flush    <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_pend_pc  <= w_pend_pc_nxt;
            r_flush    <= w_flush_nxt;
            r_misalign <= w_misalign_nxt;
        end
    end

    assign pc       = r_pc;
    assign flush    = r_flush;
    assign pending  = (r_state == ST_PEND);
    assign misalign = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Scoreboard bench for pc_sequencer: directed scenarios followed
//               by random stimulus against a behavioural next-PC model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    localparam logic [31:0] c_reset_pc = 32'h0000_0000;
    localparam logic [31:0] c_trap_pc  = 32'h0000_0080;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [1:0]  jump;
    logic [31:0] jump_target;
    logic [31:0] branch_target;
    logic [31:0] jr_target;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        flush;
    logic        pending;
    logic        illegal_sel;
    logic        misalign;

    always #5 clock = ~clock;

    pc_sequencer #(
        .RESET_PC (c_reset_pc),
        .TRAP_PC  (c_trap_pc)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .jump           (jump),
        .jump_target    (jump_target),
        .branch_target  (branch_target),
        .jr_target      (jr_target),
        .pc             (pc),
        .pc_plus4       (pc_plus4),
        .flush          (flush),
        .pending        (pending),
        .illegal_sel    (illegal_sel),
        .misalign       (misalign)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic        flush;
        logic        pending;
        logic        misalign;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: architectural PC plus an optional single buffered target.
    logic [31:0] m_pc        = 32'h0;
    bit          m_buf_valid = 1'b0;
    logic [31:0] m_buf       = 32'h0;
    bit          m_init      = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step(input bit rst, input bit stl, input bit rv, input logic [1:0] jp,
                        input logic [31:0] jt, input logic [31:0] bt, input logic [31:0] jrt);
        exp_t        e;
        logic [31:0] sel;
        logic [31:0] tgt;
        bit          legal;
        @(negedge clock);
        reset          = rst;
        stall          = stl;
        redirect_valid = rv;
        jump           = jp;
        jump_target    = jt;
        branch_target  = bt;
        jr_target      = jrt;
        #1;
        if (m_init) check("pc_plus4", pc_plus4, m_pc + 32'd4);
        check("illegal_sel", {31'h0, illegal_sel}, {31'h0, (rv && jp == 2'd3)});
        legal = rv && (jp != 2'd3);
        sel   = (jp == 2'd0) ? jt : (jp == 2'd1) ? bt : jrt;
        e.flush    = 1'b0;
        e.misalign = 1'b0;
        if (rst) begin
            m_pc        = c_reset_pc;
            m_buf_valid = 1'b0;
            m_buf       = 32'h0;
            m_init      = 1'b1;
        end else if (stl) begin
            if (legal) begin
                m_buf       = sel;
                m_buf_valid = 1'b1;
            end
        end else if (legal || m_buf_valid) begin
            tgt         = legal ? sel : m_buf;
            m_buf_valid = 1'b0;
            e.flush     = 1'b1;
`ifdef ALIGN_CHECK_EN
            if (tgt % 4 != 0) begin
                m_pc       = c_trap_pc;
                e.misalign = 1'b1;
            end else begin
                m_pc = tgt;
            end
`else
            m_pc = tgt - (tgt % 4);
`endif
        end else begin
            m_pc = m_pc + 32'd4;
        end
        e.pc      = m_pc;
        e.pending = m_buf_valid;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0);
    endtask

    // Monitor: every cycle after the edge, compare registered outputs with the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pc", pc, e.pc);
                check("flush", {31'h0, flush}, {31'h0, e.flush});
                check("pending", {31'h0, pending}, {31'h0, e.pending});
                check("misalign", {31'h0, misalign}, {31'h0, e.misalign});
            end
        end
    end

    initial begin
        logic [31:0] rt [3];
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; jump = 2'd0;
        jump_target = 32'h0; branch_target = 32'h0; jr_target = 32'h0;

        // Reset then free-run: 4, 8, 12, 16.
        step(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0);
        repeat (4) idle();
        // Jump from 0x10 to 0x400, then sequential.
        step(1'b0, 1'b0, 1'b1, 2'd0, 32'h400, 32'h0, 32'h0);
        idle();
        // jr under 3-cycle stall, released with no request.
        repeat (3) step(1'b0, 1'b1, 1'b1, 2'd2, 32'h0, 32'h0, 32'h200);
        idle();
        // Buffered 0x200 loses to a branch arriving as stall drops.
        step(1'b0, 1'b1, 1'b1, 2'd2, 32'h0, 32'h0, 32'h200);
        step(1'b0, 1'b0, 1'b1, 2'd1, 32'h0, 32'h300, 32'h0);
        // Wrap-around and illegal select.
        step(1'b0, 1'b0, 1'b1, 2'd0, 32'hFFFF_FFFC, 32'h0, 32'h0);
        idle();
        step(1'b0, 1'b0, 1'b1, 2'd3, 32'h500, 32'h600, 32'h700);
        // Misaligned target.
        step(1'b0, 1'b0, 1'b1, 2'd0, 32'h402, 32'h0, 32'h0);
        idle();
        // Reset while a redirect is buffered.
        step(1'b0, 1'b1, 1'b1, 2'd0, 32'h900, 32'h0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0);
        idle();

        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 3; k++) begin
                rt[k] = $urandom;
                if ($urandom_range(0, 3) != 0) rt[k][1:0] = 2'b00;
            end
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 4),
                 ($urandom_range(0, 9) < 4), 2'($urandom_range(0, 3)), rt[0], rt[1], rt[2]);
        end

        for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(posedge clock);
        #5;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d outstanding expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
